// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative MIPS32 multiply/divide unit holding the architectural
//            HI/LO registers. MULT/MULTU use radix-2 shift-add, DIV/DIVU use
//            restoring shift-subtract; both run on operand magnitudes and
//            fix the signs in a final cycle. Also services MTHI/MTLO.
// Ports    : CLK        - rising-edge clock
//            RST_N      - synchronous active-low reset
//            Start/Op   - launch request and operation (00 MULT, 01 MULTU,
//                         10 DIV, 11 DIVU), sampled only when not busy
//            OperandA/B - rs/rt values, captured at the Start edge
//            MoveEn/MoveSel/MoveData - MTHI (sel=1) / MTLO (sel=0) write
//            Busy       - operation in flight
//            Done       - one-cycle pulse, HI/LO hold the new result
//            HI/LO      - architectural result registers
// Config   : MDU_DIV_EN - when defined the divider datapath is built; when
//            undefined a divide request completes immediately with HI/LO
//            left unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             MoveEn,
  input  logic             MoveSel,
  input  logic [WIDTH-1:0] MoveData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int c_cntW = $clog2(WIDTH);
  localparam logic [c_cntW-1:0] c_lastCnt = c_cntW'(WIDTH - 1);

  localparam logic [1:0] c_Idle = 2'd0;
  localparam logic [1:0] c_Calc = 2'd1;
  localparam logic [1:0] c_Fix  = 2'd2;
  localparam logic [1:0] c_Done = 2'd3;

  logic [1:0]         r_state;
  logic [c_cntW-1:0]  r_count;
  // Accumulator: multiply keeps {partial product, remaining multiplier};
  // divide keeps {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] r_acc;
  // Multiplicand (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]   r_addend;
  // Negate product (multiply) or quotient (divide).
  logic               r_negQ;
`ifdef MDU_DIV_EN
  logic               r_isDiv;
  logic               r_negRem;
  logic               r_divZero;
`endif

  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mulStep;
  logic [2*WIDTH-1:0] w_prodFix;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]     w_remSh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_divStep;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;
`endif

  // Op[0] = 0 marks the signed variants (MULT, DIV).
  assign w_signA = ~Op[0] & OperandA[WIDTH-1];
  assign w_signB = ~Op[0] & OperandB[WIDTH-1];
  assign w_absA  = w_signA ? (~OperandA + 1'b1) : OperandA;
  assign w_absB  = w_signB ? (~OperandB + 1'b1) : OperandB;

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set, then shift the whole accumulator (including the carry) right.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                {1'b0, (r_acc[0] ? r_addend : {WIDTH{1'b0}})};
    w_mulStep = {w_sum, r_acc[WIDTH-1:1]};
    w_prodFix = r_negQ ? (~r_acc + 1'b1) : r_acc;
  end

`ifdef MDU_DIV_EN
  // Restoring step: shift the next dividend bit into the remainder and keep
  // the difference only when it does not borrow. With a zero divisor every
  // step succeeds, leaving an all-ones quotient and the dividend magnitude
  // as remainder, which the sign fix turns back into the original dividend.
  always_comb begin
    w_remSh = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff  = w_remSh - {1'b0, r_addend};
    if (w_diff[WIDTH]) begin
      w_divStep = {w_remSh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_divStep = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
    // A signed zero-divide would otherwise negate the all-ones quotient.
    if (r_divZero) begin
      w_quoFix = {WIDTH{1'b1}};
    end else if (r_negQ) begin
      w_quoFix = ~r_acc[WIDTH-1:0] + 1'b1;
    end else begin
      w_quoFix = r_acc[WIDTH-1:0];
    end
    w_remFix = r_negRem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                        : r_acc[2*WIDTH-1:WIDTH];
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= c_Idle;
      r_count   <= '0;
      r_acc     <= '0;
      r_addend  <= '0;
      r_negQ    <= 1'b0;
`ifdef MDU_DIV_EN
      r_isDiv   <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
`endif
      HI        <= '0;
      LO        <= '0;
    end else begin
      case (r_state)
        c_Idle, c_Done: begin
          r_state <= c_Idle;
          if (Start) begin
            // Start takes priority; a simultaneous move is dropped.
`ifdef MDU_DIV_EN
            r_state   <= c_Calc;
            r_count   <= '0;
            r_negQ    <= w_signA ^ w_signB;
            r_isDiv   <= Op[1];
            r_negRem  <= w_signA;
            r_divZero <= Op[1] & (OperandB == {WIDTH{1'b0}});
            if (Op[1]) begin
              r_acc    <= {{WIDTH{1'b0}}, w_absA};
              r_addend <= w_absB;
            end else begin
              r_acc    <= {{WIDTH{1'b0}}, w_absB};
              r_addend <= w_absA;
            end
`else
            if (Op[1]) begin
              // No divider: acknowledge immediately, HI/LO untouched.
              r_state <= c_Done;
            end else begin
              r_state  <= c_Calc;
              r_count  <= '0;
              r_negQ   <= w_signA ^ w_signB;
              r_acc    <= {{WIDTH{1'b0}}, w_absB};
              r_addend <= w_absA;
            end
`endif
          end else if (MoveEn) begin
            if (MoveSel) begin
              HI <= MoveData;
            end else begin
              LO <= MoveData;
            end
          end
        end

        c_Calc: begin
`ifdef MDU_DIV_EN
          r_acc <= r_isDiv ? w_divStep : w_mulStep;
`else
          r_acc <= w_mulStep;
`endif
          r_count <= r_count + c_cntW'(1);
          if (r_count == c_lastCnt) begin
            r_state <= c_Fix;
          end
        end

        c_Fix: begin
`ifdef MDU_DIV_EN
          if (r_isDiv) begin
            HI <= w_remFix;
            LO <= w_quoFix;
          end else begin
            HI <= w_prodFix[2*WIDTH-1:WIDTH];
            LO <= w_prodFix[WIDTH-1:0];
          end
`else
          HI <= w_prodFix[2*WIDTH-1:WIDTH];
          LO <= w_prodFix[WIDTH-1:0];
`endif
          r_state <= c_Done;
        end

        default: r_state <= c_Idle;
      endcase
    end
  end

  assign Busy = (r_state == c_Calc) || (r_state == c_Fix);
  assign Done = (r_state == c_Done);

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS32 execute stage, directly downstream of the register file: it consumes the two register read operands for MULT, MULTU, DIV and DIVU and holds the architectural HI/LO registers. It also services MTHI/MTLO and exposes HI/LO for MFHI/MFLO. A start/busy/done handshake lets the pipeline control stall while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width; the iteration count equals `WIDTH`.
- `CLK`  in  1: clock, rising-edge.
- `RST_N`  in  1: synchronous, active-low reset.
- `Start`  in  1: launch the operation in `Op`; sampled only when not busy.
- `Op`  in  2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `OperandA`  in  WIDTH: rs value; multiplicand or dividend.
- `OperandB`  in  WIDTH: rt value; multiplier or divisor.
- `MoveEn`  in  1: MTHI/MTLO write strobe.
- `MoveSel`  in  1: 1 selects HI, 0 selects LO.
- `MoveData`  in  WIDTH: MTHI/MTLO data.
- `Busy`  out  1: an operation is in flight.
- `Done`  out  1: one-cycle pulse; HI/LO hold the new result.
- `HI`, `LO`  out  WIDTH: architectural registers, registered outputs.

## Operation
- **State machine:** IDLE, CALC, FIX, DONE.
- **IDLE/DONE:** A `Start` sampled here latches `Op`, `|OperandA|` and `|OperandB|`, plus the sign flags (signed ops only). The iteration counter clears and the unit enters CALC.
- **CALC, multiply:** radix-2 shift-add, one bit per cycle, into a 2·WIDTH accumulator.
- **CALC, divide:** restoring shift-subtract, one quotient bit per cycle.
- **CALC exit:** leaves after `WIDTH` cycles (counter reaches WIDTH-1).
- **FIX:** applies sign correction.
  - MULT: the 64-bit product is negated if the operand signs differ.
  - DIV: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
- **Result write:** the edge leaving FIX writes the result (HI = upper/remainder, LO = lower/quotient) and enters DONE.
- **DONE:** lasts one cycle and behaves as IDLE for new requests.
- **Divide by zero:** LO = all ones and HI = the original dividend, for both signed and unsigned. Still full latency.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This falls out of the magnitude path and needs no special case.
- **MoveEn:** in IDLE/DONE, writes `MoveData` into the selected register at the edge. Ignored while Busy.
- **Start and MoveEn together:** if both are asserted in IDLE/DONE, Start wins and the move is dropped.
- **Start while Busy:** ignored, with no queuing.
- **Operand sampling:** operands are sampled only at the Start edge; later changes have no effect.

## Timing
- **Reset:** `RST_N` = 0 at an edge forces IDLE, `Busy` = 0, `Done` = 0, `HI` = `LO` = 0, counter 0. This applies from any state, including mid-CALC; the in-flight result is discarded.
- **Latency:** with Start sampled at edge E0:
  - `Busy` = 1 after E0 through E33;
  - after E33: `Done` = 1, `Busy` = 0, HI/LO valid (34 cycles Start-to-Done);
  - after E34: `Done` = 0 unless another op completes.
- **Back-to-back:** a Start sampled in the DONE cycle (E34) launches immediately, so throughput is one op per 34 cycles.
- **MoveEn:** HI/LO update is visible the cycle after the edge.
- **HI/LO stability:** both stay stable throughout CALC/FIX (old values) until the result edge.

## Configuration
- **`MDU_DIV_EN` defined:** full behaviour as above.
- **`MDU_DIV_EN` undefined:**
  - the divider datapath is removed and the multiply path is unchanged;
  - Start with `Op`[1] = 1 goes straight to DONE at the next edge;
  - `Done` = 1 and `Busy` = 0 after E0, `Busy` never asserts, and HI/LO are unchanged.

## Test plan
- **Reset:** hold `RST_N` = 0 two cycles -> HI = LO = 0, Busy = 0, Done = 0. Assert `RST_N` = 0 at cycle 10 of a MULT -> IDLE, HI/LO = 0, no Done pulse.
- **Multiply:** MULT 0xFFFFFFFE × 0x00000003 -> Done 34 cycles after Start, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
- **Divide:** DIV 0xFFFFFFF9 (−7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- **Divide by zero:** DIVU 0x12345678 / 0 -> LO = 0xFFFFFFFF, HI = 0x12345678, latency 34.
- **Handshake/moves:**
  - Start pulsed at cycle 5 of a busy op -> ignored, a single Done pulse.
  - MoveEn (HI, 0xDEADBEEF) while Busy -> HI is unaffected.
  - MoveEn with Start in IDLE -> move dropped.
  - Start in the DONE cycle -> second Done exactly 34 cycles later.
- **Without `MDU_DIV_EN`:** DIV Start -> Done after 1 cycle, Busy never 1, HI/LO unchanged. MULT still gives 34-cycle results.
